// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, mode constants and default widths for the timer
package timer_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
  localparam int WIDTH_DEF   = 32;
  localparam int PRESC_W_DEF = 8;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the clock by div+1 while enabled, producing a tick enable
module timer_prescaler import timer_pkg::*; #(
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  assign tick = en && cnt_q == div;
  // next prescaler value: clear wins, wrap on tick, otherwise count while enabled
  always_comb cnt_d = clr ? '0 : tick ? '0 : en ? cnt_q + PRESC_W'(1) : cnt_q;
  // prescaler register
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/timer_ctrl_32bit.sv
// timer_ctrl_32bit: start/stop timer with prescaler, period compare and sticky overflow
module timer_ctrl_32bit import timer_pkg::*; #(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [WIDTH-1:0]   period,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               ovf_clr,
  output logic [WIDTH-1:0]   count,
  output logic               busy,
  output logic               match,
  output logic               overflow,
  output logic               irq
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, period_q, period_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic mode_q, mode_d, match_q, match_d, ovf_q, ovf_d, irq_q, irq_d, tick;
  timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk(clk), .reset(reset), .clr(start | stop), .en(state_q == ST_RUN),
    .div(presc_q), .tick(tick)
  );
  // next state: stop beats start beats tick; match only with a nonzero period
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    presc_d  = presc_q;
    mode_d   = mode_q;
    match_d  = 1'b0;
    irq_d    = 1'b0;
    ovf_d    = ovf_q & ~ovf_clr;
    if (stop) state_d = ST_IDLE;
    else if (start) begin
      state_d  = ST_RUN;
      count_d  = '0;
      period_d = period;
      presc_d  = prescale;
      mode_d   = mode;
    end else if (state_q == ST_RUN && tick) begin
      if (period_q != '0 && count_q == period_q) begin
        match_d = 1'b1;
        irq_d   = 1'b1;
        count_d = mode_q == MODE_PERIODIC ? '0 : count_q;
        state_d = mode_q == MODE_PERIODIC ? ST_RUN : ST_DONE;
      end else begin
        count_d = count_q + WIDTH'(1);
        if (&count_q) begin
          ovf_d = 1'b1;
          irq_d = 1'b1;
        end
      end
    end
  end
  // state, datapath and latched configuration registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      period_q <= '0;
      presc_q  <= '0;
      mode_q   <= 1'b0;
      match_q  <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      presc_q  <= presc_d;
      mode_q   <= mode_d;
      match_q  <= match_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  assign count    = count_q;
  assign busy     = state_q == ST_RUN;
  assign match    = match_q;
  assign overflow = ovf_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_timer_ctrl_32bit.sv
// tb_timer_ctrl_32bit: directed checks of the timer controller with hand-computed values
module tb_timer_ctrl_32bit;
  logic clk = 1'b0, reset, start, stop, mode, ovf_clr;
  logic [31:0] period, count;
  logic [7:0] prescale;
  logic busy, match, overflow, irq;
  int tests = 0, fails = 0;
  timer_ctrl_32bit dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .period(period), .prescale(prescale), .ovf_clr(ovf_clr), .count(count),
    .busy(busy), .match(match), .overflow(overflow), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic tk();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [31:0] p, input logic [7:0] ps, input logic m);
    period = p; prescale = ps; mode = m; start = 1'b1;
    tk();
    start = 1'b0; period = '0; prescale = '0; mode = 1'b0;
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; ovf_clr = 1'b0;
    period = '0; prescale = '0;
    tk(); tk();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tk();
      chk("idle_count", count, 0); chk("idle_busy", 32'(busy), 0);
      chk("idle_match", 32'(match), 0); chk("idle_ovf", 32'(overflow), 0);
      chk("idle_irq", 32'(irq), 0);
    end
    go(3, 0, 1'b1);
    chk("per_start_count", count, 0); chk("per_start_busy", 32'(busy), 1);
    for (int i = 1; i <= 12; i++) begin
      tk();
      chk("per_count", count, 32'(i % 4));
      chk("per_match", 32'(match), 32'(i % 4 == 0));
      chk("per_irq", 32'(irq), 32'(i % 4 == 0));
      chk("per_busy", 32'(busy), 1);
    end
    go(2, 3, 1'b0);
    chk("os_start_count", count, 0);
    for (int i = 1; i <= 12; i++) begin
      tk();
      chk("os_count", count, i == 12 ? 32'd2 : 32'(i / 4));
      chk("os_match", 32'(match), 32'(i == 12));
      chk("os_busy", 32'(busy), 32'(i < 12));
    end
    for (int i = 0; i < 20; i++) begin
      tk();
      chk("done_count", count, 2); chk("done_busy", 32'(busy), 0);
      chk("done_match", 32'(match), 0);
    end
    go(0, 0, 1'b1);
    tk(); tk();
    chk("free_count", count, 2);
    force dut.count_q = 32'hFFFF_FFFF;
    #1 release dut.count_q;
    tk();
    chk("wrap_count", count, 0); chk("wrap_ovf", 32'(overflow), 1);
    chk("wrap_irq", 32'(irq), 1); chk("wrap_match", 32'(match), 0);
    tk();
    chk("post_wrap_count", count, 1); chk("post_wrap_ovf", 32'(overflow), 1);
    chk("post_wrap_irq", 32'(irq), 0);
    tk();
    chk("sticky_ovf", 32'(overflow), 1);
    force dut.count_q = 32'hFFFF_FFFF;
    #1 release dut.count_q;
    ovf_clr = 1'b1;
    tk();
    ovf_clr = 1'b0;
    chk("set_wins_ovf", 32'(overflow), 1); chk("set_wins_irq", 32'(irq), 1);
    chk("set_wins_count", count, 0);
    ovf_clr = 1'b1;
    tk();
    ovf_clr = 1'b0;
    chk("clr_ovf", 32'(overflow), 0); chk("clr_irq", 32'(irq), 0);
    go(10, 0, 1'b1);
    repeat (5) tk();
    chk("pre_stop_count", count, 5);
    stop = 1'b1;
    tk();
    stop = 1'b0;
    chk("stop_count", count, 5); chk("stop_busy", 32'(busy), 0);
    tk();
    chk("stop_hold", count, 5);
    start = 1'b1; stop = 1'b1;
    tk();
    start = 1'b0; stop = 1'b0;
    chk("both_busy", 32'(busy), 0); chk("both_count", count, 5);
    go(10, 0, 1'b1);
    repeat (7) tk();
    chk("pre_restart_count", count, 7);
    go(10, 0, 1'b1);
    chk("restart_count", count, 0); chk("restart_busy", 32'(busy), 1);
    repeat (3) tk();
    chk("restart_run", count, 3);
    #2 reset = 1'b1;
    #1;
    chk("async_count", count, 0); chk("async_busy", 32'(busy), 0);
    chk("async_match", 32'(match), 0); chk("async_ovf", 32'(overflow), 0);
    chk("async_irq", 32'(irq), 0);
    tk();
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tk();
      chk("rel_match", 32'(match), 0); chk("rel_irq", 32'(irq), 0);
      chk("rel_busy", 32'(busy), 0); chk("rel_count", count, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/timer_ctrl_32bit.md
Name: timer_ctrl_32bit

Overview:
- Programmable timer controller that sequences a 32-bit up-counter datapath with overflow detection.
- Provides start/stop control, a prescaler, one-shot or periodic compare against a programmed period, a sticky overflow flag and an interrupt pulse.
- Sits between the control/register logic and the counter datapath. Software-visible status is taken from its registered outputs.

Parameters:
- WIDTH, 32, counter and period width.
- PRESC_W, 8, prescaler divide-value width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse: latch config, clear count, begin counting.
- stop  input  1  single-cycle pulse: halt counting and return to IDLE.
- mode  input  1  0 = one-shot, 1 = periodic; sampled only on an accepted start.
- period  input  WIDTH  compare value; 0 = free-running (no match); sampled on start.
- prescale  input  PRESC_W  tick every prescale+1 clocks; sampled on start.
- ovf_clr  input  1  clears the sticky overflow flag.
- count  output  WIDTH  current count value.
- busy  output  1  high while in RUN.
- match  output  1  one-cycle pulse when count reaches period.
- overflow  output  1  sticky flag; set when count wraps from all-ones to 0.
- irq  output  1  one-cycle pulse on a match or an overflow set event.

Behaviour:
- Reset (async, while asserted): state IDLE; count=0; busy=0; match=0; overflow=0; irq=0; prescaler counter=0; latched config=0.
- All outputs are registered.
- States are IDLE, RUN and DONE.
- IDLE: count holds its value. A start moves to RUN; on that edge latch mode/period/prescale, set count=0 and prescaler=0.
- RUN: the prescaler increments every clock. When prescaler==prescale_l, the prescaler returns to 0 and a tick occurs that cycle. prescale_l=0 gives a tick every clock in RUN.
- Action on a tick:
  - If period_l!=0 and count==period_l: match=1 and irq=1 for the next cycle. Periodic mode: count<=0, stay in RUN. One-shot mode: count holds period_l, go to DONE.
  - Otherwise: count<=count+1 (mod 2^WIDTH). If count was all-ones, set overflow=1 and pulse irq.
- Latency: with start accepted at edge k and prescale=0, count=1 after edge k+1. Match asserts after the edge where count==period and the next tick occurs, i.e. period+1 ticks after start.
- DONE: busy=0; count holds. A start re-enters RUN as from IDLE. A stop goes to IDLE.
- busy=1 exactly when state==RUN.
- stop in RUN: go to IDLE, count holds its current value, prescaler=0, no match.
- start and stop in the same cycle: stop wins.
- start while in RUN: restart. Re-latch config, count=0, prescaler=0.
- overflow is sticky. ovf_clr clears it. If a set event and ovf_clr occur in the same cycle, set wins.
- A match and an overflow in the same cycle are impossible: period=0 disables match, and count never exceeds a nonzero period. irq is a single pulse regardless.
- Config inputs are ignored outside an accepted start.
- Reset asserted mid-RUN: immediate return to the reset state. No pulses after reset release until the next start.

Decomposition:
- Package timer_pkg holds:
  - state encoding (ST_IDLE, ST_RUN, ST_DONE);
  - mode constants MODE_ONESHOT=0, MODE_PERIODIC=1;
  - the default WIDTH/PRESC_W values.
- Sub-module timer_prescaler (clk, reset, clr, en, div, tick): generates the tick enable.
- The compare, counter and FSM stay in timer_ctrl_32bit.

Test Plan:
1. reset pulse, then idle 5 cycles -> count=0, busy=0, match=0, overflow=0, irq=0 throughout.
2. period=3, prescale=0, mode=1, start -> count 0,1,2,3,0,1,... Match and irq pulse each time count returns from 3 to 0 (every 4 cycles). busy stays 1.
3. period=2, prescale=3, mode=0, start -> count increments every 4 clocks to 2. Match pulses once, then state DONE, busy=0, count holds 2 for 20+ cycles.
4. period=0, prescale=0: start, then force count=32'hFFFFFFFF -> next cycle count=0, overflow=1, irq one-cycle pulse. overflow stays 1 until ovf_clr; ovf_clr together with another wrap keeps overflow=1.
5. period=10 RUN: stop at count=5 -> IDLE, busy=0, count holds 5. start and stop asserted together -> remains IDLE.
6. period=10 RUN: start at count=7 -> count restarts at 0. Assert reset mid-RUN -> all outputs 0 asynchronously, no match after release.
